// File: rtl/seg7_time_display.sv
// MM.SS time display: binary minutes/seconds to BCD, multiplexed onto a 4-digit
// common-anode 7-segment display with a per-frame snapshot and optional field blink.
module seg7_time_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] seconds_in,
  input  logic [5:0] minutes_in,
  input  logic       blink_en,
  input  logic       blink_field,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic [5:0]    snap_sec;
  logic [5:0]    snap_min;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    an_hold;

  logic          tick;
  logic          frame_end;
  logic [5:0]    field_val;
  logic [3:0]    tens;
  logic [5:0]    units;
  logic [3:0]    digit;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    if (v >= 6'd50)      bcd_tens = 4'd5;
    else if (v >= 6'd40) bcd_tens = 4'd4;
    else if (v >= 6'd30) bcd_tens = 4'd3;
    else if (v >= 6'd20) bcd_tens = 4'd2;
    else if (v >= 6'd10) bcd_tens = 4'd1;
    else                 bcd_tens = 4'd0;
  endfunction

  function automatic logic [6:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 7'b1000000;
      4'd1:    font = 7'b1111001;
      4'd2:    font = 7'b0100100;
      4'd3:    font = 7'b0110000;
      4'd4:    font = 7'b0011001;
      4'd5:    font = 7'b0010010;
      4'd6:    font = 7'b0000010;
      4'd7:    font = 7'b1111000;
      4'd8:    font = 7'b0000000;
      4'd9:    font = 7'b0010000;
      default: font = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    tick      = (pre == PW'(SCAN_DIV - 1));
    frame_end = tick && (idx == 2'd3);
    // Digit 0 reads the live inputs because the snapshot is captured on that same tick.
    if (idx == 2'd0)      field_val = seconds_in;
    else if (idx == 2'd1) field_val = snap_sec;
    else                  field_val = snap_min;
    tens     = bcd_tens(field_val);
    units    = field_val - (6'(tens) * 6'd10);
    digit    = idx[0] ? tens : units[3:0];
    seg_next = (field_val > 6'd59) ? 7'b0111111 : font(digit);
    an_next  = ~(4'b0001 << idx);
    if (blink_en && !blink_phase && (blink_field == idx[1])) an_next = 4'b1111;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre         <= '0;
      idx         <= 2'd0;
      snap_sec    <= 6'd0;
      snap_min    <= 6'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      an_hold     <= 4'b1111;
      an_n        <= 4'b1111;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      frame_done  <= 1'b0;
    end else if (enable) begin
      pre        <= tick ? '0 : pre + PW'(1);
      frame_done <= frame_end;
      if (tick) begin
        idx     <= idx + 2'd1;
        seg_n   <= seg_next;
        dp_n    <= (idx != 2'd2);
        an_hold <= an_next;
        an_n    <= an_next;
        if (idx == 2'd0) begin
          snap_sec <= seconds_in;
          snap_min <= minutes_in;
        end
      end else begin
        an_n <= an_hold;
      end
      if (!blink_en) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (frame_end) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end else begin
      // Frozen scan: keep all counters, just blank the anodes.
      an_n       <= 4'b1111;
      frame_done <= 1'b0;
    end
  end

endmodule
